ascon_perm_engine: RTL and testbench
====================================

# ascon_perm_engine

Memory-mapped Ascon permutation engine that holds the 320-bit Ascon state and applies p^a/p^b on it in place. Round count is selected per start, and rounds per clock are a build parameter. Completion is reported by status polling and an optional interrupt. It sits on the same 32-bit chip-select bus as the existing permutation peripheral and replaces it in designs that need both p^12 and p^6/p^8, or higher throughput.

## Interface
- UNROLL, 1: rounds evaluated per clock; legal values are 1 or 2.
- DEFAULT_ROUNDS, 12: reset value of CTRL.rounds.
- iClk  in  1  clock; all logic is on the rising edge.
- iReset  in  1  reset; synchronous and active-high.
- iChip_select_n  in  1  bus select, active-low.
- iRead_n  in  1  read strobe, active-low; qualified by select.
- iWrite_n  in  1  write strobe, active-low; qualified by select.
- iAddress  in  5  word address.
- iWriteData  in  32  write data.
- oReadData  out  32  registered read data.
- oIrq  out  1  level interrupt, equal to STATUS.done AND CTRL.irq_en.

## Operation
- Register map (word addresses):
  - 0–9: state words. Address 2k is the low 32 bits of xk, address 2k+1 is the high 32 bits of xk, for k = 0..4.
  - 10 CTRL (R/W):
    - bit0 start: write-only, reads 0.
    - bits[7:4] rounds: 1..12.
    - bit8 irq_en.
  - 11 STATUS:
    - bit0 busy: RO.
    - bit1 done: sticky, write 1 to clear.
    - bit2 err: sticky, write 1 to clear.
  - 12 CYCLES (RO): number of clocks taken by the last permutation.
  - Other addresses read 0; writes to them are ignored.
- FSM has two states, IDLE and RUN.
- IDLE → RUN on a CTRL write with start=1 and 1 ≤ rounds ≤ 12:
  - the rounds field is latched as nr;
  - the round index r is loaded with 12−nr;
  - done is cleared.
- A start request with rounds = 0 or rounds > 12:
  - sets err;
  - stays in IDLE;
  - still updates CTRL.rounds and irq_en.
- Round i applies, in order:
  - constant addition: x2 ^= {56'b0, (0xF−i)<<4 | i};
  - the 5-bit S-box layer (bitsliced over 64 lanes);
  - the linear layer, where xk ^= ROR(xk,a) ^ ROR(xk,b) with rotation pairs x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- In RUN, each clock applies min(UNROLL, 12−r) rounds to the state register and advances r by the same amount.
- When r reaches 12:
  - → IDLE;
  - done is set;
  - CYCLES is loaded.
- The result overwrites the state in place, so consecutive starts chain permutations without reloading.
- Writes to state words or CTRL while busy are ignored; a start while busy is ignored and does not set err.
- Reads while busy return the intermediate state.
- STATUS write-1-to-clear on done in the same cycle that done is being set: the set wins.
- CYCLES is a 5-bit count padded with zeros.

## Timing
- Reset values:
  - state: all 0;
  - CTRL.rounds = DEFAULT_ROUNDS, irq_en = 0;
  - busy, done, err = 0;
  - CYCLES = 0;
  - oReadData = 0;
  - oIrq = 0.
- A write takes effect on the clock edge where select and write strobe are both low. The read and write strobes must not both be low in the same cycle; if they are, the write is performed and read data is unspecified.
- Read latency is 1: oReadData updates on the edge after the read cycle and holds until the next read.
- busy reads 1 starting the cycle after the start write.
- Permutation latency is ceil(nr/UNROLL) clocks of RUN. On the edge that ends the last round: busy→0, done→1, and oIrq→1 if enabled.
- Reset asserted in RUN aborts immediately. All registers return to their reset values and the partial state is discarded.
- Start is honoured on the same edge that done is set to 0.

## Test plan
- Reset, then read addresses 0–13 → all 0 except CTRL = 0x000000C0 (DEFAULT_ROUNDS = 12).
- Load state x0..x4 = 0x0123456789ABCDEF, 0, 0, 0, 0 and start with rounds = 12, UNROLL = 1:
  - busy stays high exactly 12 clocks;
  - done = 1 and CYCLES = 12;
  - the 10 state words match the C reference model p^12.
  - Repeat with UNROLL = 2 → CYCLES = 6, same state.
- Start with rounds = 6, then again with rounds = 6, without reloading → final state equals the model's p^6(p^6(s)). With UNROLL = 2 and rounds = 7 → CYCLES = 4, and the state matches the model's p^7.
- While busy:
  - write 0xFFFFFFFF to address 0 and issue a start → no effect;
  - the final state matches the model;
  - err stays 0.
- Start with rounds = 0 or 13 → err = 1, busy stays 0, state unchanged. Writing 0x4 to STATUS clears err.
- Set irq_en and start → oIrq rises with done. Writing 0x2 to STATUS lowers oIrq the next cycle. Asserting iReset in the third RUN cycle → all registers read their reset values.

Source files
------------

// File: rtl/ascon_perm_engine.sv
// Ascon p^a/p^b permutation engine on a 32-bit chip-select bus.
// Holds the 320-bit state, runs 1..12 rounds per start, UNROLL rounds per clock.
module ascon_perm_engine #(
   parameter int UNROLL         = 1,
   parameter int DEFAULT_ROUNDS = 12
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iChip_select_n,
   input  logic        iRead_n,
   input  logic        iWrite_n,
   input  logic [4:0]  iAddress,
   input  logic [31:0] iWriteData,
   output logic [31:0] oReadData,
   output logic        oIrq
);
   typedef enum logic {IDLE, RUN} fsm_e;
   typedef logic [4:0][63:0] st_t;

   localparam logic [4:0] A_CTRL   = 5'd10;
   localparam logic [4:0] A_STATUS = 5'd11;
   localparam logic [4:0] A_CYCLES = 5'd12;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   fsm_e        fsm_q, fsm_d;
   st_t         x_q, x_d;
   logic [3:0]  rounds_q, rounds_d;
   logic [3:0]  r_q, r_d;
   logic        irq_en_q, irq_en_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [4:0]  cyc_q, cyc_d;
   logic [4:0]  cycles_q, cycles_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;

   logic        wr, rd, busy;
   logic [3:0]  r_step;
   st_t         one_round, two_rounds;

   function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // S-box is applied as a 5-bit lookup per lane; x0 is the index MSB.
   function automatic st_t ascon_round(input st_t s, input logic [3:0] i);
      st_t        t;
      logic [4:0] o;
      t = s;
      t[2][7:0] = t[2][7:0] ^ {4'hF - i, i};
      for (int j = 0; j < 64; j++) begin
         o = SBOX[{t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]}];
         {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]} = o;
      end
      t[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      t[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      t[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
      t[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      t[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
      return t;
   endfunction

   assign wr         = !iChip_select_n && !iWrite_n;
   assign rd         = !iChip_select_n && !iRead_n;
   assign busy       = (fsm_q == RUN);
   assign r_step     = (UNROLL == 2 && r_q <= 4'd10) ? 4'd2 : 4'd1;
   assign one_round  = ascon_round(x_q, r_q);
   assign two_rounds = ascon_round(one_round, r_q + 4'd1);

   // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      fsm_d    = fsm_q;
      x_d      = x_q;
      rounds_d = rounds_q;
      r_d      = r_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      cyc_d    = cyc_q;
      cycles_d = cycles_q;
      rdata_d  = rdata_q;

      if (rd) begin
         rdata_d = 32'h0;
         for (int k = 0; k < 5; k++) begin
            if (iAddress == 5'(2 * k))     rdata_d = x_q[k][31:0];
            if (iAddress == 5'(2 * k + 1)) rdata_d = x_q[k][63:32];
         end
         case (iAddress)
            A_CTRL:   rdata_d = {23'h0, irq_en_q, rounds_q, 4'h0};
            A_STATUS: rdata_d = {29'h0, err_q, done_q, busy};
            A_CYCLES: rdata_d = {27'h0, cycles_q};
            default:  ;
         endcase
      end

      if (wr && iAddress == A_STATUS) begin
         if (iWriteData[1]) done_d = 1'b0;
         if (iWriteData[2]) err_d  = 1'b0;
      end

      case (fsm_q)
         IDLE: begin
            if (wr) begin
               for (int k = 0; k < 5; k++) begin
                  if (iAddress == 5'(2 * k))     x_d[k][31:0]  = iWriteData;
                  if (iAddress == 5'(2 * k + 1)) x_d[k][63:32] = iWriteData;
               end
               if (iAddress == A_CTRL) begin
                  rounds_d = iWriteData[7:4];
                  irq_en_d = iWriteData[8];
                  if (iWriteData[0]) begin
                     if (iWriteData[7:4] != 4'd0 && iWriteData[7:4] <= 4'd12) begin
                        fsm_d  = RUN;
                        r_d    = 4'd12 - iWriteData[7:4];
                        done_d = 1'b0;
                        cyc_d  = 5'd0;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
         end
         RUN: begin
            x_d   = (r_step == 4'd2) ? two_rounds : one_round;
            r_d   = r_q + r_step;
            cyc_d = cyc_q + 5'd1;
            // Completion overrides a same-cycle write-1-to-clear of done.
            if (r_d == 4'd12) begin
               fsm_d    = IDLE;
               done_d   = 1'b1;
               cycles_d = cyc_q + 5'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase

      irq_d = done_d & irq_en_d;
   end

   // NOTE: sequential state uses <= only; the state register is reset like any other flop because it is architecturally visible.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         fsm_q    <= IDLE;
         x_q      <= '0;
         rounds_q <= 4'(DEFAULT_ROUNDS);
         r_q      <= 4'd0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cyc_q    <= 5'd0;
         cycles_q <= 5'd0;
         rdata_q  <= 32'h0;
         irq_q    <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         x_q      <= x_d;
         rounds_q <= rounds_d;
         r_q      <= r_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cyc_q    <= cyc_d;
         cycles_q <= cycles_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   assign oReadData = rdata_q;
   assign oIrq      = irq_q;
endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine: drives UNROLL=1 and UNROLL=2 copies in lockstep
// and checks read data against an independent bitsliced Ascon model.
module tb_ascon_perm_engine;
   typedef logic [4:0][63:0] st_t;
   typedef struct {
      string       nm;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, cs_n, rd_n, wr_n;
   logic [4:0]  addr;
   logic [31:0] wdata, rdata1, rdata2;
   logic        irq1, irq2;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ascon_perm_engine #(.UNROLL(1), .DEFAULT_ROUNDS(12)) u_dut1 (
      .iClk(clk), .iReset(rst), .iChip_select_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
      .iAddress(addr), .iWriteData(wdata), .oReadData(rdata1), .oIrq(irq1));

   ascon_perm_engine #(.UNROLL(2), .DEFAULT_ROUNDS(12)) u_dut2 (
      .iClk(clk), .iReset(rst), .iChip_select_n(cs_n), .iRead_n(rd_n), .iWrite_n(wr_n),
      .iAddress(addr), .iWriteData(wdata), .oReadData(rdata2), .oIrq(irq2));

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, got, exp);
      end
   endtask

   // Reference model in the C-reference boolean form.
   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      logic [63:0] r;
      for (int j = 0; j < 64; j++) r[j] = v[(j + n) % 64];
      return r;
   endfunction

   function automatic st_t model_round(input st_t s, input int i);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x2 = x2 ^ 64'((15 - i) * 16 + i);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x4, x3, x2, x1, x0};
   endfunction

   function automatic st_t model_perm(input st_t s, input int nr);
      st_t t = s;
      for (int i = 12 - nr; i < 12; i++) t = model_round(t, i);
      return t;
   endfunction

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; wdata = d;
   endtask

   task automatic bus_rd(input logic [4:0] a, input string nm, input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      @(negedge clk);
      cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a;
      e.nm = nm; e.e1 = e1; e.e2 = e2;
      sb.push_back(e);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic wait_done();
      bus_idle();
      repeat (14) @(negedge clk);
   endtask

   task automatic read_state(input string nm, input st_t s);
      logic [63:0] v;
      logic [31:0] word;
      for (int w = 0; w < 10; w++) begin
         v    = s[w / 2];
         word = (w % 2 == 1) ? v[63:32] : v[31:0];
         bus_rd(5'(w), $sformatf("%s_w%0d", nm, w), word, word);
      end
   endtask

   // Monitor: a read sampled on a rising edge is presented by the next falling edge.
   initial begin
      bit   fire;
      exp_t e;
      forever begin
         @(posedge clk);
         fire = !cs_n && !rd_n && !rst;
         @(negedge clk);
         if (fire) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_underflow: got read with no expectation queued");
            end else begin
               e = sb.pop_front();
               check({e.nm, "/u1"}, rdata1, e.e1);
               check({e.nm, "/u2"}, rdata2, e.e2);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      st_t ms;
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0; wdata = '0; rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int a = 0; a < 14; a++)
         bus_rd(5'(a), $sformatf("rst_a%0d", a), (a == 10) ? 32'hC0 : 32'h0, (a == 10) ? 32'hC0 : 32'h0);
      bus_idle();
      check("rst_irq1", 32'(irq1), 32'h0);
      check("rst_irq2", 32'(irq2), 32'h0);

      // p^12 from a loaded state, with exact busy-window tracking.
      ms = '0;
      ms[0] = 64'h0123456789ABCDEF;
      bus_wr(5'd0, 32'h89ABCDEF);
      bus_wr(5'd1, 32'h01234567);
      bus_wr(5'd10, 32'h0000_00C1);
      for (int k = 1; k <= 14; k++)
         bus_rd(5'd11, $sformatf("p12_busy_k%0d", k), (k <= 12) ? 32'h1 : 32'h2, (k <= 6) ? 32'h1 : 32'h2);
      ms = model_perm(ms, 12);
      bus_rd(5'd12, "p12_cycles", 32'd12, 32'd6);
      read_state("p12", ms);

      // Chained p^6 twice without reloading.
      bus_wr(5'd10, 32'h0000_0061);
      wait_done();
      bus_wr(5'd10, 32'h0000_0061);
      wait_done();
      ms = model_perm(model_perm(ms, 6), 6);
      bus_rd(5'd12, "p6x2_cycles", 32'd6, 32'd3);
      bus_rd(5'd10, "p6x2_ctrl", 32'h60, 32'h60);
      read_state("p6x2", ms);

      // p^7 exercises the odd tail of the two-round datapath.
      bus_wr(5'd10, 32'h0000_0071);
      wait_done();
      ms = model_perm(ms, 7);
      bus_rd(5'd12, "p7_cycles", 32'd7, 32'd4);
      read_state("p7", ms);

      // State write and restart while busy must be ignored.
      bus_wr(5'd10, 32'h0000_00C1);
      bus_wr(5'd0, 32'hFFFF_FFFF);
      bus_wr(5'd10, 32'h0000_0061);
      wait_done();
      ms = model_perm(ms, 12);
      bus_rd(5'd11, "busy_wr_status", 32'h2, 32'h2);
      bus_rd(5'd10, "busy_wr_ctrl", 32'hC0, 32'hC0);
      read_state("busy_wr", ms);

      // Illegal round counts set err, leave busy low and keep the state.
      bus_wr(5'd10, 32'h0000_0001);
      bus_rd(5'd11, "r0_status", 32'h6, 32'h6);
      bus_rd(5'd10, "r0_ctrl", 32'h00, 32'h00);
      bus_wr(5'd10, 32'h0000_00D1);
      bus_rd(5'd11, "r13_status", 32'h6, 32'h6);
      bus_rd(5'd10, "r13_ctrl", 32'hD0, 32'hD0);
      read_state("err", ms);
      bus_wr(5'd11, 32'h0000_0004);
      bus_rd(5'd11, "err_clr", 32'h2, 32'h2);
      bus_wr(5'd11, 32'h0000_0002);
      bus_rd(5'd11, "done_clr", 32'h0, 32'h0);

      // Interrupt follows done, then drops after write-1-to-clear.
      bus_wr(5'd10, 32'h0000_01C1);
      bus_idle();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("irq1_k%0d", k), 32'(irq1), (k >= 12) ? 32'h1 : 32'h0);
         check($sformatf("irq2_k%0d", k), 32'(irq2), (k >= 6) ? 32'h1 : 32'h0);
      end
      ms = model_perm(ms, 12);
      bus_wr(5'd11, 32'h0000_0002);
      bus_idle();
      check("irq1_clr", 32'(irq1), 32'h0);
      check("irq2_clr", 32'(irq2), 32'h0);
      bus_rd(5'd10, "irq_ctrl", 32'h1C0, 32'h1C0);
      read_state("irq", ms);

      // Reset sampled on the third RUN edge discards everything.
      bus_wr(5'd10, 32'h0000_01C1);
      bus_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 14; a++)
         bus_rd(5'(a), $sformatf("abort_a%0d", a), (a == 10) ? 32'hC0 : 32'h0, (a == 10) ? 32'hC0 : 32'h0);
      bus_idle();
      check("abort_irq1", 32'(irq1), 32'h0);
      check("abort_irq2", 32'(irq2), 32'h0);

      repeat (2) @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
